// File: rtl/inst_decode_if.sv
// rtl/inst_decode_if.sv - fetch/decode/execute handshake and decode bundle
interface inst_decode_if #(
  parameter int DW = 32
);
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [DW-1:0] if_pc;
  logic          if_ready;
  logic          ex_ready;
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [5:0]    id_opcode;
  logic [5:0]    id_funct;
  logic [4:0]    id_shamt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [4:0]    id_dest;
  logic [DW-1:0] id_imm;
  logic [DW-1:0] id_br_target;
  logic [DW-1:0] id_jtarget;
  logic          id_is_load;
  logic          id_is_store;
  logic          id_is_branch;
  logic          id_is_jump;
  logic          id_illegal;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, id_valid, id_pc, id_opcode, id_funct, id_shamt,
           id_rs_data, id_rt_data, id_dest, id_imm, id_br_target, id_jtarget,
           id_is_load, id_is_store, id_is_branch, id_is_jump, id_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, id_valid, id_pc, id_opcode, id_funct, id_shamt,
           id_rs_data, id_rt_data, id_dest, id_imm, id_br_target, id_jtarget,
           id_is_load, id_is_store, id_is_branch, id_is_jump, id_illegal
  );
endinterface

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - decode stage: field split, register file, load-use stall
module inst_decode #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  inst_decode_if.slave  bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  logic [DW-1:0] rf [NREG];

  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm16;
  logic [DW-1:0] rs_data, rt_data, imm, pc_plus4, br_target, jtarget;
  logic [4:0]    dest;
  logic          is_load, is_store, is_branch, is_jump, illegal;
  logic          zext, rs_used, rt_used;
  logic          hazard, adv, xfer;

  assign opcode = bus.if_instr[31:26];
  assign rs     = bus.if_instr[25:21];
  assign rt     = bus.if_instr[20:16];
  assign rd     = bus.if_instr[15:11];
  assign imm16  = bus.if_instr[15:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    dest      = 5'd0;
    zext      = 1'b0;
    rs_used   = 1'b1;
    rt_used   = 1'b0;
    case (opcode)
      OP_RTYPE: begin dest = rd; rt_used = 1'b1; end
      OP_LW:    begin is_load = 1'b1; dest = rt; end
      OP_SW:    begin is_store = 1'b1; rt_used = 1'b1; end
      OP_ADDI:  dest = rt;
      OP_ANDI,
      OP_ORI:   begin dest = rt; zext = 1'b1; end
      OP_BEQ,
      OP_BNE:   begin is_branch = 1'b1; rt_used = 1'b1; end
      OP_J:     begin is_jump = 1'b1; rs_used = 1'b0; end
      default:  illegal = 1'b1;
    endcase
  end

  assign imm       = zext ? {{(DW-16){1'b0}}, imm16} : {{(DW-16){imm16[15]}}, imm16};
  assign pc_plus4  = bus.if_pc + DW'(4);
  assign br_target = pc_plus4 + (imm << 2);
  assign jtarget   = {pc_plus4[31:28], bus.if_instr[25:0], 2'b00};

  // Same-cycle write-back is forwarded so decode never sees a stale operand.
  assign rs_data = (rs == 5'd0) ? '0 : (wb_en && wb_addr == rs) ? wb_data : rf[rs];
  assign rt_data = (rt == 5'd0) ? '0 : (wb_en && wb_addr == rt) ? wb_data : rf[rt];

  assign hazard = bus.id_valid && bus.id_is_load && (bus.id_dest != 5'd0) && bus.if_valid &&
                  ((rs_used && rs == bus.id_dest) || (rt_used && rt == bus.id_dest));
  assign adv         = !bus.id_valid || bus.ex_ready;
  assign bus.if_ready = adv && !hazard && !reset && !flush;
  assign xfer        = bus.if_valid && bus.if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Flush beats both transfer and hold; a bubble only clears id_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.id_valid     <= 1'b0;
      bus.id_pc        <= '0;
      bus.id_opcode    <= '0;
      bus.id_funct     <= '0;
      bus.id_shamt     <= '0;
      bus.id_rs_data   <= '0;
      bus.id_rt_data   <= '0;
      bus.id_dest      <= '0;
      bus.id_imm       <= '0;
      bus.id_br_target <= '0;
      bus.id_jtarget   <= '0;
      bus.id_is_load   <= 1'b0;
      bus.id_is_store  <= 1'b0;
      bus.id_is_branch <= 1'b0;
      bus.id_is_jump   <= 1'b0;
      bus.id_illegal   <= 1'b0;
    end else if (flush) begin
      bus.id_valid <= 1'b0;
    end else if (adv) begin
      bus.id_valid <= xfer;
      if (xfer) begin
        bus.id_pc        <= bus.if_pc;
        bus.id_opcode    <= opcode;
        bus.id_funct     <= bus.if_instr[5:0];
        bus.id_shamt     <= bus.if_instr[10:6];
        bus.id_rs_data   <= rs_data;
        bus.id_rt_data   <= rt_data;
        bus.id_dest      <= dest;
        bus.id_imm       <= imm;
        bus.id_br_target <= br_target;
        bus.id_jtarget   <= jtarget;
        bus.id_is_load   <= is_load;
        bus.id_is_store  <= is_store;
        bus.id_is_branch <= is_branch;
        bus.id_is_jump   <= is_jump;
        bus.id_illegal   <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_inst_decode.sv
// tb/tb_inst_decode.sv - table and scoreboard bench for inst_decode
module tb_inst_decode;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  inst_decode_if #(.DW(32)) ifc ();

  inst_decode #(.DW(32), .NREG(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [4:0]  flags;   // {load, store, branch, jump, illegal}
    bit          chk_imm;
    logic [31:0] imm;
    logic [31:0] br;
    logic [31:0] jt;
    bit          wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_rf [32];
  vec_t        sb [$];
  vec_t        pend;
  vec_t        tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [4:0] dest, input logic [4:0] flags, input bit ci,
                              input logic [31:0] imm, input logic [31:0] br, input logic [31:0] jt);
    vec_t v;
    v.instr = instr; v.pc = pc; v.dest = dest; v.flags = flags; v.chk_imm = ci;
    v.imm = imm; v.br = br; v.jt = jt;
    v.wb_en = 1'b0; v.wb_addr = 5'd0; v.wb_data = 32'd0;
    v.rs_data = 32'd0; v.rt_data = 32'd0;
    return v;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return ref_rf[a];
  endfunction

  task automatic cmp_bundle(input vec_t e);
    chk("id_valid", 32'(ifc.id_valid), 32'd1);
    chk("id_pc", ifc.id_pc, e.pc);
    chk("id_opcode", 32'(ifc.id_opcode), 32'(e.instr[31:26]));
    chk("id_funct", 32'(ifc.id_funct), 32'(e.instr[5:0]));
    chk("id_shamt", 32'(ifc.id_shamt), 32'(e.instr[10:6]));
    chk("id_rs_data", ifc.id_rs_data, e.rs_data);
    chk("id_rt_data", ifc.id_rt_data, e.rt_data);
    chk("id_dest", 32'(ifc.id_dest), 32'(e.dest));
    chk("id_flags", 32'({ifc.id_is_load, ifc.id_is_store, ifc.id_is_branch,
                         ifc.id_is_jump, ifc.id_illegal}), 32'(e.flags));
    chk("id_jtarget", ifc.id_jtarget, e.jt);
    if (e.chk_imm) begin
      chk("id_imm", ifc.id_imm, e.imm);
      chk("id_br_target", ifc.id_br_target, e.br);
    end
  endtask

  // One clock: push the expected bundle on transfer, compare it one cycle later.
  task automatic tick(output bit fired);
    #1;
    fired = ifc.if_valid && ifc.if_ready;
    if (fired) begin
      vec_t e;
      e = pend;
      e.rs_data = rd_model(pend.instr[25:21]);
      e.rt_data = rd_model(pend.instr[20:16]);
      sb.push_back(e);
    end
    if (wb_en && !reset && wb_addr != 5'd0) ref_rf[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    if (fired) begin
      if (sb.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
      else cmp_bundle(sb.pop_front());
    end
  endtask

  task automatic drive(input vec_t v);
    pend         = v;
    ifc.if_valid = 1'b1;
    ifc.if_instr = v.instr;
    ifc.if_pc    = v.pc;
    wb_en        = v.wb_en;
    wb_addr      = v.wb_addr;
    wb_data      = v.wb_data;
  endtask

  task automatic present(input vec_t v);
    bit f;
    f = 1'b0;
    drive(v);
    for (int n = 0; n < 16 && !f; n++) tick(f);
    if (!f) chk("accept_timeout", 32'd0, 32'd1);
    ifc.if_valid = 1'b0;
    wb_en        = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bit f;
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick(f);
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    vec_t add5, lw4, add_use4, add_rd4, bypass;
    bit   f;

    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    add5     = mk(32'h00A01820, 32'h40,  5'd3, 5'b00000, 0, 32'h0, 32'h0, 32'h02806080);
    lw4      = mk(32'h8C040000, 32'h400, 5'd4, 5'b10000, 1, 32'h0, 32'h404, 32'h00100000);
    add_use4 = mk(32'h00800820, 32'h404, 5'd1, 5'b00000, 0, 32'h0, 32'h0, 32'h02002080);
    add_rd4  = mk(32'h00222020, 32'h404, 5'd4, 5'b00000, 0, 32'h0, 32'h0, 32'h00888080);
    bypass   = mk(32'h8CE20000, 32'h80,  5'd2, 5'b10000, 1, 32'h0, 32'h84, 32'h03880000);
    bypass.wb_en = 1'b1; bypass.wb_addr = 5'd7; bypass.wb_data = 32'hDEADBEEF;

    tbl.push_back(add5);
    tbl.push_back(mk(32'h20C2FFFC, 32'h44,  5'd2, 5'b00000, 1, 32'hFFFFFFFC, 32'h38,    32'h030BFFF0));
    tbl.push_back(mk(32'h3524FFFC, 32'h48,  5'd4, 5'b00000, 1, 32'h0000FFFC, 32'h4003C, 32'h0493FFF0));
    tbl.push_back(mk(32'h10A6FFFF, 32'h100, 5'd0, 5'b00100, 1, 32'hFFFFFFFF, 32'h100,   32'h029BFFFC));
    tbl.push_back(mk(32'hACC50010, 32'h200, 5'd0, 5'b01000, 1, 32'h10,       32'h244,   32'h03140040));
    tbl.push_back(mk(32'h08100000, 32'hF0000000, 5'd0, 5'b00010, 0, 32'h0,   32'h0,     32'hF0400000));
    tbl.push_back(mk(32'hFFFFFFFF, 32'h300, 5'd0, 5'b00001, 0, 32'h0,        32'h0,     32'h0FFFFFFC));
    tbl.push_back(mk(32'h30078001, 32'hFFFFFFFC, 5'd7, 5'b00000, 1, 32'h8001, 32'h20004, 32'h001E0004));
    tbl.push_back(bypass);

    // Reset with write-back enabled must leave the register file clear.
    reset = 1'b1; flush = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFF;
    ifc.ex_ready = 1'b1; ifc.if_valid = 1'b0; ifc.if_instr = 32'd0; ifc.if_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_if_ready", 32'(ifc.if_ready), 32'd0);
    chk("reset_id_valid", 32'(ifc.id_valid), 32'd0);
    chk("reset_id_pc", ifc.id_pc, 32'd0);
    chk("reset_id_dest", 32'(ifc.id_dest), 32'd0);
    chk("reset_id_imm", ifc.id_imm, 32'd0);
    chk("reset_id_br_target", ifc.id_br_target, 32'd0);
    reset = 1'b0; wb_en = 1'b0;
    #1;
    chk("post_reset_if_ready", 32'(ifc.if_ready), 32'd1);

    present(add5);
    wb_write(5'd5, 32'h00001234);
    wb_write(5'd6, 32'hCAFE0006);
    wb_write(5'd9, 32'h00000009);
    foreach (tbl[i]) present(tbl[i]);

    // Load-use: one cycle of if_ready=0 and exactly one bubble.
    present(lw4);
    drive(add_use4);
    #1;
    chk("hazard_if_ready", 32'(ifc.if_ready), 32'd0);
    tick(f);
    chk("hazard_no_accept", 32'(f), 32'd0);
    chk("hazard_bubble", 32'(ifc.id_valid), 32'd0);
    tick(f);
    chk("hazard_then_issue", 32'(f), 32'd1);
    ifc.if_valid = 1'b0;

    // Same pair, but the add only writes r4: no stall.
    present(lw4);
    drive(add_rd4);
    #1;
    chk("no_hazard_if_ready", 32'(ifc.if_ready), 32'd1);
    tick(f);
    chk("no_hazard_accept", 32'(f), 32'd1);
    ifc.if_valid = 1'b0;

    // Back-pressure: bundle holds for three cycles.
    present(tbl[1]);
    ifc.ex_ready = 1'b0;
    drive(tbl[2]);
    for (int c = 0; c < 3; c++) begin
      tick(f);
      chk("stall_no_accept", 32'(f), 32'd0);
      chk("stall_if_ready", 32'(ifc.if_ready), 32'd0);
      chk("stall_id_valid", 32'(ifc.id_valid), 32'd1);
      chk("stall_id_pc", ifc.id_pc, 32'h44);
      chk("stall_id_imm", ifc.id_imm, 32'hFFFFFFFC);
    end
    ifc.ex_ready = 1'b1;
    tick(f);
    chk("stall_release_accept", 32'(f), 32'd1);
    ifc.if_valid = 1'b0;

    // Flush: instruction offered during flush is refused, then re-accepted.
    drive(tbl[3]);
    flush = 1'b1;
    #1;
    chk("flush_if_ready", 32'(ifc.if_ready), 32'd0);
    tick(f);
    chk("flush_no_accept", 32'(f), 32'd0);
    chk("flush_id_valid", 32'(ifc.id_valid), 32'd0);
    flush = 1'b0;
    tick(f);
    chk("flush_reaccept", 32'(f), 32'd1);
    ifc.if_valid = 1'b0;

    // Reset in mid-flight drops the held bundle.
    present(tbl[4]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_id_valid", 32'(ifc.id_valid), 32'd0);
    chk("midreset_id_pc", ifc.id_pc, 32'd0);
    reset = 1'b0;
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_decode.md
Name: inst_decode

Overview:
- Decode stage directly downstream of the fetch stage.
- Accepts a 32-bit instruction word plus its PC from fetch, splits out the fields and reads a 32x32 register file with two read ports and one write-back port.
- Produces a registered decode bundle for the execute stage.
- Detects load-use hazards, inserts a bubble and back-pressures fetch through a valid/ready handshake.

Parameters:
- DW, 32, data/instruction width
- NREG, 32, register file depth (5-bit addresses)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents a valid instruction
- if_instr  in  32  instruction word from fetch
- if_pc  in  32  PC of if_instr
- if_ready  out  1  decode accepts if_instr this cycle
- ex_ready  in  1  execute can take the decode bundle
- flush  in  1  kill the bundle held in decode (branch redirect)
- wb_en  in  1  register write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  32  write-back data
- id_valid  out  1  bundle valid
- id_pc  out  32  PC of decoded instruction
- id_opcode  out  6  instr[31:26]
- id_funct  out  6  instr[5:0]
- id_shamt  out  5  instr[10:6]
- id_rs_data  out  32  register[rs]
- id_rt_data  out  32  register[rt]
- id_dest  out  5  destination register; 0 when no write
- id_imm  out  32  extended immediate
- id_br_target  out  32  id_pc + 4 + (id_imm << 2), mod 2^32
- id_jtarget  out  32  {pc_plus4[31:28], instr[25:0], 2'b00}
- id_is_load / id_is_store / id_is_branch / id_is_jump / id_illegal  out  1 each  class flags

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on posedge clk only.
- Reset: all id_* outputs 0, all 32 registers 0, if_ready 0 during the reset cycle.
- Reset mid-operation discards the held bundle.
- Fields: rs=[25:21], rt=[20:16], rd=[15:11], imm16=[15:0].
- Decode table:
  - 0x00 R-type: dest=rd.
  - 0x23 lw: load, dest=rt, sign-extended imm.
  - 0x2B sw: store, dest=0, sign-extended imm.
  - 0x08 addi: dest=rt, sign-extended imm.
  - 0x0C andi / 0x0D ori: dest=rt, zero-extended imm.
  - 0x04 beq / 0x05 bne: branch, dest=0, sign-extended imm.
  - 0x02 j: jump, dest=0.
  - Any other opcode: id_illegal=1, dest=0, all other flags 0.
- Register file:
  - Register 0 reads 0 always; writes to it are ignored.
  - Write on posedge when wb_en is set.
  - Write-through bypass: a read of the same address in the same cycle as a write returns wb_data.
  - Write-back is independent of stall, flush and handshake state.
- Operand use for hazards:
  - rs is used by every opcode except j.
  - rt is used by R-type, sw, beq and bne.
- Hazard: asserted when all of the following hold:
  - id_valid, id_is_load and id_dest != 0.
  - id_dest equals a used rs or rt of if_instr.
  - if_valid.
- Handshake:
  - adv = !id_valid || ex_ready.
  - if_ready = adv && !hazard && !reset.
  - A transfer occurs when if_valid && if_ready. One-cycle latency: the bundle appears on id_* at the next posedge.
  - adv && !(if_valid && if_ready): id_valid <= 0 (bubble). A hazard therefore inserts exactly one bubble when ex_ready=1.
  - !adv: all id_* hold. While stalled, id_* are stable and if_ready is 0.
- Flush:
  - id_valid <= 0 next cycle; an instruction presented in the flush cycle is not accepted (if_ready=0 while flush=1).
  - Flush overrides transfer and hold.
  - Reset overrides flush.
- Arithmetic: all PC arithmetic is modulo 2^32 with no overflow flag. pc_plus4 = id_pc + 4.

Test Plan:
- Reset with wb_en=1 -> register file unchanged (all 0), id_valid=0, if_ready=0; after release if_ready=1.
- Write-back then decode: write r5=0x0000_1234, then R-type add rd=3, rs=5, rt=0 at pc 0x40 -> next cycle id_valid=1, id_rs_data=0x1234, id_rt_data=0, id_dest=3, id_pc=0x40.
- Bypass: same cycle wb_en=1 r7=0xDEAD_BEEF while decoding lw rt=2, rs=7 -> id_rs_data=0xDEADBEEF, id_is_load=1, id_dest=2.
- Immediates: addi imm=0xFFFC -> id_imm=0xFFFF_FFFC; ori imm=0xFFFC -> 0x0000_FFFC; beq at pc 0x100 with imm=0xFFFF -> id_br_target=0x100.
- Load-use: lw r4 followed by add rs=4 with ex_ready=1 -> if_ready=0 for 1 cycle, one id_valid=0 bubble, then the add issues. The same pair with rd of add = 4 but rs/rt != 4 -> no stall.
- Back-pressure and flush:
  - ex_ready=0 for 3 cycles -> id_* stable, if_ready=0.
  - flush=1 -> id_valid=0 next cycle; the instruction presented during the flush cycle is re-accepted later.
  - Opcode 0x3F -> id_illegal=1, id_dest=0.
